// File: rtl/alu24_issue.sv
// rtl/alu24_issue.sv - issue/writeback sequencer driving a combinational 24-bit ALU
module alu24_issue #(
    parameter int DATA_W = 24,
    parameter int REG_N  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_aluop,
    input  logic [$clog2(REG_N)-1:0]  in_rs,
    input  logic [$clog2(REG_N)-1:0]  in_rt,
    input  logic [$clog2(REG_N)-1:0]  in_rd,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic                      in_use_imm,
    input  logic                      in_reg_write,
    input  logic                      in_is_beq,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [2:0]                alu_op,
    input  logic [DATA_W-1:0]         alu_y,
    input  logic                      alu_z,
    output logic                      wb_valid,
    output logic [$clog2(REG_N)-1:0]  wb_rd,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      br_taken,
    input  logic [$clog2(REG_N)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]         dbg_data
);
    localparam int AW = $clog2(REG_N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rf_q [REG_N];
    logic [DATA_W-1:0]   alu_a_q, alu_b_q, wb_data_q;
    logic [2:0]          alu_op_q;
    logic [AW-1:0]       rd_q;
    logic                reg_write_q, is_beq_q, z_q;
    logic                accept;
    logic [DATA_W-1:0]   rs_val, rt_val;

    // r0 is hardwired to zero on every read port.
    assign rs_val   = (in_rs == '0)    ? '0 : rf_q[in_rs];
    assign rt_val   = (in_rt == '0)    ? '0 : rf_q[in_rt];
    assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

    assign accept = (state_q == S_IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        wb_valid = 1'b0;
        br_taken = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = !rst;
            S_WB: begin
                wb_valid = 1'b1;
                br_taken = is_beq_q && z_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 3'b000;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            is_beq_q    <= 1'b0;
            wb_data_q   <= '0;
            z_q         <= 1'b0;
            for (int i = 0; i < REG_N; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                alu_a_q     <= rs_val;
                rd_q        <= in_rd;
                is_beq_q    <= in_is_beq;
                // A branch never writes back, whatever the decoder says.
                reg_write_q <= in_reg_write && !in_is_beq;
                if (in_is_beq) begin
                    // Add the negated rt so the ALU zero flag reports rs == rt.
                    alu_op_q <= 3'b000;
                    alu_b_q  <= ~rt_val + DATA_W'(1);
                end else begin
                    alu_op_q <= in_aluop;
                    alu_b_q  <= in_use_imm ? in_imm : rt_val;
                end
            end
            if (state_q == S_EXEC) begin
                wb_data_q <= alu_y;
                z_q       <= alu_z;
            end
            if ((state_q == S_WB) && reg_write_q && (rd_q != '0)) begin
                rf_q[rd_q] <= wb_data_q;
            end
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_op  = alu_op_q;
    assign wb_rd   = rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_alu24_issue.sv
// tb/tb_alu24_issue.sv - scoreboard bench for alu24_issue with a behavioural ALU
module tb_alu24_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_aluop;
    logic [3:0]  in_rs, in_rt, in_rd;
    logic [23:0] in_imm;
    logic        in_use_imm, in_reg_write, in_is_beq;
    logic [23:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [23:0] alu_y;
    logic        alu_z;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [23:0] wb_data;
    logic        br_taken;
    logic [3:0]  dbg_addr;
    logic [23:0] dbg_data;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]  rd;
        logic [23:0] data;
        logic        br;
        int          acc;
    } exp_t;
    exp_t sb[$];

    alu24_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_reg_write(in_reg_write), .in_is_beq(in_is_beq),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_z(alu_z),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .br_taken(br_taken),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        alu_y = '0;
        case (alu_op)
            3'b000:  alu_y = alu_a + alu_b;
            3'b001:  alu_y = alu_a * alu_b;
            3'b010:  alu_y = alu_b;
            3'b011:  alu_y = alu_a + alu_b;
            3'b100:  alu_y = alu_a | alu_b;
            3'b101:  alu_y = alu_b;
            3'b110:  alu_y = alu_a >> alu_b[4:0];
            default: alu_y = '0;
        endcase
        alu_z = (alu_y == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_wb: got wb_rd %h wb_data %h expected no writeback", wb_rd, wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", 32'(wb_data), 32'(e.data));
                chk("br_taken", 32'(br_taken), 32'(e.br));
                chk("wb_latency_edge", 32'(cyc), 32'(e.acc + 1));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, input logic [23:0] imm, input logic ui,
                         input logic rw, input logic beq, input logic [23:0] exp_data,
                         input logic exp_br, input logic push);
        int guard;
        exp_t e;
        @(negedge clk);
        in_aluop = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
        in_use_imm = ui; in_reg_write = rw; in_is_beq = beq; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
        if (push) begin
            e.rd = rd; e.data = exp_data; e.br = exp_br; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input logic [3:0] a, input logic [23:0] exp, input string name);
        dbg_addr = a;
        #1 chk(name, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  rdy_exp;
        logic [23:0] hold_imm [5];
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; in_aluop = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_use_imm = 1'b0; in_reg_write = 1'b0; in_is_beq = 1'b0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_br_taken", 32'(br_taken), 32'd0);
        rst = 1'b0;

        // LI r1=5 ; ADD r2=r1+r1
        issue(3'b010, 4'd0, 4'd0, 4'd1, 24'd5, 1'b1, 1'b1, 1'b0, 24'd5, 1'b0, 1'b1);
        @(negedge clk);
        chk("exec_in_ready", 32'(in_ready), 32'd0);
        chk("exec_alu_b_li", 32'(alu_b), 32'd5);
        @(negedge clk);
        chk("wb_in_ready", 32'(in_ready), 32'd0);
        drain();
        issue(3'b000, 4'd1, 4'd1, 4'd2, 24'd0, 1'b0, 1'b1, 1'b0, 24'd10, 1'b0, 1'b1);
        drain();
        chk_reg(4'd2, 24'd10, "r2_add");
        chk_reg(4'd1, 24'd5, "r1_li");

        // Signed multiply
        issue(3'b010, 4'd0, 4'd0, 4'd3, 24'hFFFFFD, 1'b1, 1'b1, 1'b0, 24'hFFFFFD, 1'b0, 1'b1);
        issue(3'b010, 4'd0, 4'd0, 4'd4, 24'd7, 1'b1, 1'b1, 1'b0, 24'd7, 1'b0, 1'b1);
        drain();
        issue(3'b001, 4'd3, 4'd4, 4'd5, 24'd0, 1'b0, 1'b1, 1'b0, 24'hFFFFEB, 1'b0, 1'b1);
        drain();
        chk_reg(4'd5, 24'hFFFFEB, "r5_mul");

        // BEQ r1,r1 with misleading aluop/imm/reg_write
        issue(3'b110, 4'd1, 4'd1, 4'd7, 24'h000123, 1'b1, 1'b1, 1'b1, 24'h000000, 1'b1, 1'b1);
        @(negedge clk);
        chk("beq_alu_a", 32'(alu_a), 32'd5);
        chk("beq_alu_b", 32'(alu_b), 32'h00FFFFFB);
        chk("beq_alu_op", 32'(alu_op), 32'd0);
        drain();
        chk_reg(4'd7, 24'd0, "r7_beq_nowrite");
        // BEQ r1,r2: 5 + (-10) = -5
        issue(3'b000, 4'd1, 4'd2, 4'd8, 24'd0, 1'b0, 1'b1, 1'b1, 24'hFFFFFB, 1'b0, 1'b1);
        drain();
        chk_reg(4'd8, 24'd0, "r8_beq_nowrite");
        chk_reg(4'd1, 24'd5, "r1_after_beq");

        // r0 writes are dropped; r0 reads as zero
        issue(3'b010, 4'd0, 4'd0, 4'd0, 24'h123456, 1'b1, 1'b1, 1'b0, 24'h123456, 1'b0, 1'b1);
        drain();
        chk_reg(4'd0, 24'd0, "r0_ignored");
        issue(3'b000, 4'd0, 4'd1, 4'd9, 24'd0, 1'b0, 1'b1, 1'b0, 24'd5, 1'b0, 1'b1);
        drain();
        chk_reg(4'd9, 24'd5, "r9_r0_src");

        // Hold in_valid for 5 cycles while the fields change every cycle
        rdy_exp = 5'b01001;
        hold_imm[0] = 24'h11; hold_imm[1] = 24'h22; hold_imm[2] = 24'h33;
        hold_imm[3] = 24'h44; hold_imm[4] = 24'h55;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_aluop = 3'b010; in_rs = '0; in_rt = '0; in_rd = 4'(10 + k);
            in_imm = hold_imm[k]; in_use_imm = 1'b1; in_reg_write = 1'b1;
            in_is_beq = 1'b0; in_valid = 1'b1;
            chk("hold_in_ready", 32'(in_ready), 32'(rdy_exp[k]));
            if (in_ready) begin
                e.rd = 4'(10 + k); e.data = hold_imm[k]; e.br = 1'b0; e.acc = cyc + 1;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        chk_reg(4'd10, 24'h11, "r10_hold");
        chk_reg(4'd13, 24'h44, "r13_hold");
        chk_reg(4'd11, 24'h0, "r11_hold_ignored");
        chk_reg(4'd14, 24'h0, "r14_hold_ignored");

        // Reset during EXEC aborts LI r6=9
        issue(3'b010, 4'd0, 4'd0, 4'd6, 24'd9, 1'b1, 1'b1, 1'b0, 24'd9, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exec_in_ready", 32'(in_ready), 32'd0);
        chk("rst_exec_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("post_rst_alu_a", 32'(alu_a), 32'd0);
        chk("post_rst_alu_b", 32'(alu_b), 32'd0);
        chk("post_rst_alu_op", 32'(alu_op), 32'd0);
        chk("post_rst_wb_data", 32'(wb_data), 32'd0);
        chk("post_rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("post_rst_br_taken", 32'(br_taken), 32'd0);
        chk_reg(4'd6, 24'd0, "r6_aborted");
        chk_reg(4'd1, 24'd0, "r1_cleared");
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
